// File: rtl/vga_beat_scheduler.sv
// Beat scheduler for the VGA face renderer: turns a BPM estimate into a beat
// period, then advances the face and flashes a filter, committing only at frame ends.
module vga_beat_scheduler #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BPM_MIN      = 30,
  parameter int BPM_MAX      = 300,
  parameter int FLASH_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bpm,
  input  logic        bpm_valid,
  input  logic        auto_cycle,
  input  logic [1:0]  face_manual,
  input  logic [1:0]  filter_mode,
  input  logic        vid_valid,
  input  logic        vid_ready,
  input  logic        vid_eop,
  output logic [1:0]  face_select,
  output logic [3:0]  filter_select,
  output logic        beat_pulse,
  output logic        period_valid,
  output logic        div_busy
);

  localparam logic [31:0] NUMER      = 32'(longint'(CLK_HZ) * 64'd60);
  localparam logic [15:0] BPM_LO     = 16'(BPM_MIN);
  localparam logic [15:0] BPM_HI     = 16'(BPM_MAX);
  localparam logic [3:0]  FLASH_LAST = 4'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

  div_state_t  div_state_q, div_state_d;
  logic [4:0]  bit_cnt_q;
  logic [15:0] bpm_lat_q, pend_bpm_q;
  logic        pend_vld_q;
  logic [15:0] divisor_q, rem_q;
  logic [31:0] quo_q;
  logic        period_valid_q;
  logic [31:0] period_q, beat_cnt_q;
  logic [1:0]  pending_face_q, face_q;
  logic        flash_req_q;
  logic [3:0]  frames_left_q, filter_q;

  logic        bpm_in_range, bpm_reject, bpm_accept;
  logic        div_start, div_done;
  logic [15:0] div_src;
  logic [16:0] trial;
  logic        trial_ge;
  logic [15:0] trial_diff;
  logic        beat, commit;

  assign bpm_in_range = (bpm >= BPM_LO) && (bpm <= BPM_HI);
  assign bpm_reject   = bpm_valid && !bpm_in_range;
  assign bpm_accept   = bpm_valid && bpm_in_range && (bpm != bpm_lat_q);

  // Intake / divider control
  always_comb begin
    div_state_d = div_state_q;
    div_start   = 1'b0;
    div_done    = 1'b0;
    div_src     = bpm_accept ? bpm : pend_bpm_q;
    case (div_state_q)
      D_IDLE: begin
        if (!bpm_reject && (bpm_accept || pend_vld_q)) begin
          div_start   = 1'b1;
          div_state_d = D_BUSY;
        end
      end
      D_BUSY: begin
        if (bpm_reject)
          div_state_d = D_IDLE;
        else if (bit_cnt_q == 5'd31)
          div_state_d = D_DONE;
      end
      D_DONE: begin
        div_done    = !bpm_reject;
        div_state_d = D_IDLE;
      end
      default: div_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_state_q <= D_IDLE;
    else          div_state_q <= div_state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q  <= '0;
      bpm_lat_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_bpm_q <= '0;
    end else begin
      if (div_start)
        bit_cnt_q <= '0;
      else if (div_state_q == D_BUSY)
        bit_cnt_q <= bit_cnt_q + 5'd1;
      if (bpm_reject)
        bpm_lat_q <= '0;
      else if (bpm_accept)
        bpm_lat_q <= bpm;
      // A value arriving while a division is in flight waits in the slot; newest wins.
      if (bpm_reject || div_start)
        pend_vld_q <= 1'b0;
      else if (bpm_accept) begin
        pend_vld_q <= 1'b1;
        pend_bpm_q <= bpm;
      end
    end
  end

  // Restoring division datapath, one quotient bit per cycle
  assign trial      = {rem_q, quo_q[31]};
  assign trial_ge   = trial >= {1'b0, divisor_q};
  assign trial_diff = trial[15:0] - divisor_q;

  always_ff @(posedge clk) begin
    if (div_start) begin
      divisor_q <= div_src;
      rem_q     <= '0;
      quo_q     <= NUMER;
    end else if (div_state_q == D_BUSY) begin
      rem_q <= trial_ge ? trial_diff : trial[15:0];
      quo_q <= {quo_q[30:0], trial_ge};
    end
  end

  // Beat timer; a new period only takes effect at the next reload
  assign beat = period_valid_q && (beat_cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_valid_q <= 1'b0;
      period_q       <= '0;
      beat_cnt_q     <= '0;
    end else if (bpm_reject) begin
      period_valid_q <= 1'b0;
      beat_cnt_q     <= '0;
    end else begin
      if (div_done) begin
        period_q <= quo_q;
        if (!period_valid_q) begin
          period_valid_q <= 1'b1;
          beat_cnt_q     <= quo_q - 32'd1;
        end
      end
      if (period_valid_q) begin
        if (beat_cnt_q == '0)
          beat_cnt_q <= period_q - 32'd1;
        else
          beat_cnt_q <= beat_cnt_q - 32'd1;
      end
    end
  end

  // Frame-boundary commit of face and flash filter
  assign commit = vid_valid && vid_ready && vid_eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_face_q <= '0;
      face_q         <= '0;
      flash_req_q    <= 1'b0;
      frames_left_q  <= '0;
      filter_q       <= '0;
    end else begin
      if (!auto_cycle)
        pending_face_q <= face_manual;
      else if (beat)
        pending_face_q <= (pending_face_q == 2'd2) ? 2'd0 : pending_face_q + 2'd1;
      if (beat)
        flash_req_q <= 1'b1;
      else if (commit)
        flash_req_q <= 1'b0;
      if (commit) begin
        face_q <= pending_face_q;
        if (flash_req_q) begin
          filter_q      <= 4'b0001 << filter_mode;
          frames_left_q <= FLASH_LAST;
        end else if (frames_left_q != '0)
          frames_left_q <= frames_left_q - 4'd1;
        else
          filter_q <= '0;
      end
    end
  end

  assign face_select   = face_q;
  assign filter_select = filter_q;
  assign beat_pulse    = beat;
  assign period_valid  = period_valid_q;
  assign div_busy      = (div_state_q == D_BUSY);

endmodule

// File: tb/tb_vga_beat_scheduler.sv
// Randomized self-checking bench for vga_beat_scheduler with a frame-level reference model.
module tb_vga_beat_scheduler;

  localparam int CLK_HZ = 1000;
  localparam int FF     = 4;
  localparam int P300   = 60000 / 300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bpm = '0;
  logic        bpm_valid = 1'b0;
  logic        auto_cycle = 1'b1;
  logic [1:0]  face_manual = '0;
  logic [1:0]  filter_mode = '0;
  logic        vid_valid = 1'b0;
  logic        vid_ready = 1'b1;
  logic        vid_eop = 1'b0;
  logic [1:0]  face_select;
  logic [3:0]  filter_select;
  logic        beat_pulse, period_valid, div_busy;

  vga_beat_scheduler #(.CLK_HZ(CLK_HZ), .BPM_MIN(30), .BPM_MAX(300), .FLASH_FRAMES(FF)) dut (
    .clk(clk), .reset_n(reset_n), .bpm(bpm), .bpm_valid(bpm_valid),
    .auto_cycle(auto_cycle), .face_manual(face_manual), .filter_mode(filter_mode),
    .vid_valid(vid_valid), .vid_ready(vid_ready), .vid_eop(vid_eop),
    .face_select(face_select), .filter_select(filter_select),
    .beat_pulse(beat_pulse), .period_valid(period_valid), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, busy_cnt = 0, beat_total = 0;
  int m_pend = 0, m_req = 0, m_face = 0, m_filter = 0, m_left = 0, m_code = 0;
  bit coincide = 0;

  // Frame-level model: face shown is the face pending at the frame end; a flash
  // request lights the filter for the next FF frames with the mode seen at its start.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_pend = 0; m_req = 0; m_face = 0; m_filter = 0; m_left = 0; m_code = 0;
    end else begin
      if (div_busy) busy_cnt++;
      if (vid_valid && vid_ready && vid_eop) begin
        m_face = m_pend;
        if (m_req != 0) begin m_code = 1 << filter_mode; m_left = FF; m_req = 0; end
        if (m_left > 0) begin m_filter = m_code; m_left--; end
        else m_filter = 0;
        coincide = beat_pulse;
      end
      if (beat_pulse) begin
        beat_total++;
        if (auto_cycle) m_pend = (m_pend + 1) % 3;
        m_req = 1;
      end
      if (!auto_cycle) m_pend = int'(face_manual);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    tick(1);
    bpm = v; bpm_valid = 1'b1;
    tick(1);
    bpm_valid = 1'b0;
  endtask

  task automatic commit_frame();
    tick(1);
    vid_valid = 1'b1; vid_ready = 1'b1; vid_eop = 1'b1;
    tick(1);
    vid_valid = 1'b0; vid_eop = 1'b0;
  endtask

  task automatic wait_pv(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      smp();
      if (period_valid) ok = 1;
    end
  endtask

  task automatic wait_beat(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      smp();
      if (beat_pulse) ok = 1;
    end
  endtask

  task automatic do_reset();
    tick(1);
    reset_n = 1'b0; bpm_valid = 1'b0; vid_valid = 1'b0; vid_eop = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      bpm = 16'd120; bpm_valid = 1'b1;
      vid_valid = 1'b1; vid_eop = 1'b1; vid_ready = 1'b1;
    end
    smp();
    checks++; if (face_select !== 2'd0) begin failures++; $display("FAIL reset_face got=%0d exp=0", face_select); end
    checks++; if (filter_select !== 4'd0) begin failures++; $display("FAIL reset_filter got=%b exp=0000", filter_select); end
    checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL reset_beat got=%b exp=0", beat_pulse); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", period_valid); end
    checks++; if (div_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
    tick(1);
    bpm_valid = 1'b0; vid_valid = 1'b0; vid_eop = 1'b0;
    reset_n = 1'b1;
    tick(3);
    checks++; if (div_busy !== 1'b0 || period_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle busy=%b pv=%b exp=0,0", div_busy, period_valid);
    end
  endtask

  task automatic test_divide();
    int vals[6];
    int p, rise, prev;
    bit ok;
    vals[0] = 120; vals[1] = 30; vals[2] = 300;
    for (int i = 3; i < 6; i++) vals[i] = $urandom_range(100, 299);
    foreach (vals[i]) begin
      p = 60000 / vals[i];
      strobe(16'd0);
      smp();
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL div_clear_pv bpm=%0d got=%b exp=0", vals[i], period_valid); end
      busy_cnt = 0;
      strobe(16'(vals[i]));
      wait_pv(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL div_pv_rise bpm=%0d got=0 exp=1", vals[i]); end
      checks++; if (busy_cnt != 32) begin failures++; $display("FAIL div_busy_len bpm=%0d got=%0d exp=32", vals[i], busy_cnt); end
      rise = cyc;
      wait_beat(p + 20, ok);
      checks++; if (!ok || cyc - rise != p - 1) begin
        failures++; $display("FAIL first_beat bpm=%0d got=%0d exp=%0d", vals[i], cyc - rise, p - 1);
      end
      for (int k = 0; k < 2; k++) begin
        prev = cyc;
        wait_beat(p + 20, ok);
        checks++; if (!ok || cyc - prev != p) begin
          failures++; $display("FAIL beat_interval bpm=%0d got=%0d exp=%0d", vals[i], cyc - prev, p);
        end
      end
    end
    busy_cnt = 0;
    strobe(16'(vals[5]));
    tick(5);
    checks++; if (busy_cnt != 0) begin failures++; $display("FAIL same_bpm_no_div got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_out_of_range();
    int b0;
    bit ok;
    strobe(16'd20);
    smp();
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL oor_low_pv got=%b exp=0", period_valid); end
    b0 = beat_total;
    tick(2500);
    checks++; if (beat_total != b0) begin failures++; $display("FAIL oor_low_beats got=%0d exp=%0d", beat_total, b0); end
    strobe(16'd120);
    wait_pv(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL oor_rearm_pv got=0 exp=1"); end
    strobe(16'd301);
    smp();
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL oor_high_pv got=%b exp=0", period_valid); end
  endtask

  task automatic test_update();
    int rise, prev;
    bit ok;
    strobe(16'd0);
    busy_cnt = 0;
    strobe(16'd60);
    tick(5);
    strobe(16'd240);
    wait_pv(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL upd_pv got=0 exp=1"); end
    rise = cyc;
    tick(80);
    checks++; if (busy_cnt != 64) begin failures++; $display("FAIL upd_two_divs got=%0d exp=64", busy_cnt); end
    wait_beat(1100, ok);
    checks++; if (!ok || cyc - rise != 999) begin failures++; $display("FAIL upd_first_period got=%0d exp=999", cyc - rise); end
    for (int k = 0; k < 2; k++) begin
      prev = cyc;
      wait_beat(300, ok);
      checks++; if (!ok || cyc - prev != 250) begin failures++; $display("FAIL upd_new_period got=%0d exp=250", cyc - prev); end
    end
  endtask

  task automatic test_face();
    bit ok;
    do_reset();
    auto_cycle = 1'b1;
    filter_mode = 2'($urandom_range(0, 3));
    strobe(16'd300);
    wait_pv(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL face_pv got=0 exp=1"); end
    for (int k = 1; k <= 3; k++) begin
      wait_beat(P300 + 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL face_beat%0d timeout", k); end
      tick($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) filter_mode = 2'($urandom_range(0, 3));
      commit_frame();
      checks++; if (face_select !== 2'(k % 3)) begin failures++; $display("FAIL face_cycle%0d got=%0d exp=%0d", k, face_select, k % 3); end
      checks++; if (filter_select !== 4'(m_filter)) begin failures++; $display("FAIL face_filter%0d got=%b exp=%b", k, filter_select, 4'(m_filter)); end
    end
    auto_cycle = 1'b0; face_manual = 2'd2;
    tick(2);
    commit_frame();
    checks++; if (face_select !== 2'd2) begin failures++; $display("FAIL face_manual got=%0d exp=2", face_select); end
    auto_cycle = 1'b1;
  endtask

  task automatic test_flash();
    logic [3:0] exp;
    bit ok;
    filter_mode = 2'd1;
    wait_beat(P300 + 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL flash_beat timeout"); end
    tick(2);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) filter_mode = 2'($urandom_range(0, 3));
      commit_frame();
      exp = (k <= FF) ? 4'b0010 : 4'b0000;
      checks++; if (filter_select !== exp) begin failures++; $display("FAIL flash_commit%0d got=%b exp=%b", k, filter_select, exp); end
      checks++; if (face_select !== 2'(m_face)) begin failures++; $display("FAIL flash_face%0d got=%0d exp=%0d", k, face_select, m_face); end
    end
  endtask

  task automatic test_corner();
    int pre, held;
    bit ok;
    auto_cycle = 1'b1;
    filter_mode = 2'($urandom_range(0, 3));
    wait_beat(P300 + 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL corner_beat timeout"); end
    pre = m_pend;
    coincide = 0;
    repeat (P300) @(posedge clk);
    #1;
    vid_valid = 1'b1; vid_ready = 1'b1; vid_eop = 1'b1;
    tick(1);
    vid_valid = 1'b0; vid_eop = 1'b0;
    checks++; if (!coincide) begin failures++; $display("FAIL corner_coincide got=0 exp=1"); end
    checks++; if (face_select !== 2'(pre)) begin failures++; $display("FAIL corner_prebeat_face got=%0d exp=%0d", face_select, pre); end
    checks++; if (filter_select !== 4'(m_filter)) begin failures++; $display("FAIL corner_filter got=%b exp=%b", filter_select, 4'(m_filter)); end
    tick(3);
    commit_frame();
    checks++; if (face_select !== 2'((pre + 1) % 3)) begin failures++; $display("FAIL corner_next_face got=%0d exp=%0d", face_select, (pre + 1) % 3); end
    wait_beat(P300 + 20, ok);
    held = m_face;
    tick(2);
    vid_valid = 1'b1; vid_ready = 1'b0; vid_eop = 1'b1;
    tick(2);
    vid_valid = 1'b0; vid_eop = 1'b0; vid_ready = 1'b1;
    checks++; if (face_select !== 2'(held)) begin failures++; $display("FAIL noready_face got=%0d exp=%0d", face_select, held); end
    commit_frame();
    checks++; if (face_select !== 2'((held + 1) % 3)) begin failures++; $display("FAIL ready_face got=%0d exp=%0d", face_select, (held + 1) % 3); end
    checks++; if (filter_select !== 4'(m_filter)) begin failures++; $display("FAIL ready_filter got=%b exp=%b", filter_select, 4'(m_filter)); end
  endtask

  task automatic test_async_reset();
    int b0;
    bit ok;
    strobe(16'd0);
    strobe(16'd120);
    tick(10);
    checks++; if (div_busy !== 1'b1) begin failures++; $display("FAIL ar_busy_before got=%b exp=1", div_busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (div_busy !== 1'b0 || period_valid !== 1'b0 || face_select !== 2'd0) begin
      failures++; $display("FAIL ar_mid_div busy=%b pv=%b face=%0d exp=0,0,0", div_busy, period_valid, face_select);
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    filter_mode = 2'd3;
    strobe(16'd300);
    wait_pv(100, ok);
    wait_beat(P300 + 20, ok);
    commit_frame();
    checks++; if (filter_select !== 4'b1000) begin failures++; $display("FAIL ar_flash_on got=%b exp=1000", filter_select); end
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (filter_select !== 4'd0 || face_select !== 2'd0 || period_valid !== 1'b0 || beat_pulse !== 1'b0) begin
      failures++; $display("FAIL ar_mid_flash filt=%b face=%0d pv=%b beat=%b exp=0", filter_select, face_select, period_valid, beat_pulse);
    end
    tick(2);
    reset_n = 1'b1;
    b0 = beat_total;
    tick(2500);
    checks++; if (beat_total != b0 || period_valid !== 1'b0) begin
      failures++; $display("FAIL ar_no_beats beats=%0d exp=%0d pv=%b", beat_total - b0, 0, period_valid);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_out_of_range();
    test_update();
    test_face();
    test_flash();
    test_corner();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_beat_scheduler.md
Name: vga_beat_scheduler

Overview:
- Sequences the VGA face renderer from the tempo estimate: converts BPM into a beat period, cycles the displayed face on every beat, and flashes a colour filter for a fixed number of frames after each beat.
- Sits between the BPM estimator and the VGA face source. Drives that block's face_select and filter_select.
- Observes the face source's Avalon-ST handshake so that all changes take effect only at frame boundaries, which prevents tearing.

Parameters:
- CLK_HZ, 50_000_000: clock frequency. CLK_HZ*60 must fit in 32 bits.
- BPM_MIN, 30: lowest accepted BPM. Lower values disable beats.
- BPM_MAX, 300: highest accepted BPM. Higher values disable beats.
- FLASH_FRAMES, 4: number of frames the filter stays applied after each beat; range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- bpm  in  16  tempo estimate, integer BPM
- bpm_valid  in  1  one-cycle strobe; bpm is sampled when high
- auto_cycle  in  1  1: face advances on each beat; 0: face follows face_manual
- face_manual  in  2  face used when auto_cycle=0 (0 Wolf, 1 P2, 2 Colour)
- filter_mode  in  2  flash filter: 0 invert, 1 lighten, 2 darken, 3 greyscale
- vid_valid  in  1  face source valid
- vid_ready  in  1  VGA sink ready
- vid_eop  in  1  face source endofpacket
- face_select  out  2  to face source
- filter_select  out  4  to face source, one-hot: 0001 invert, 0010 lighten, 0100 darken, 1000 greyscale; 0000 means no filter
- beat_pulse  out  1  one-cycle pulse per beat
- period_valid  out  1  beat timer running
- div_busy  out  1  divider active

Behaviour:
- Reset (async assert, sync release): face_select=0, filter_select=0, beat_pulse=0, period_valid=0, div_busy=0. All counters, pending flags and latched BPM are cleared. Reset mid-divide or mid-flash abandons the operation.
- BPM intake: on bpm_valid, an in-range bpm (BPM_MIN..BPM_MAX inclusive) that differs from the latched value starts the divider.
  - An out-of-range bpm clears period_valid immediately, stops beats, and clears the latched value.
  - If bpm_valid arrives while div_busy=1, the value is held in a one-deep pending slot; a newer value overwrites it. The pending division starts the cycle after the current one finishes.
- Divider FSM D_IDLE -> D_BUSY -> D_DONE -> D_IDLE:
  - Restoring unsigned division, 32-bit numerator CLK_HZ*60, 16-bit divisor bpm, one quotient bit per cycle. div_busy is high for exactly 32 cycles.
  - D_DONE lasts one cycle and writes new_period = quotient; any remainder is truncated.
  - Division by zero cannot occur, because bpm below BPM_MIN never starts the divider.
- Beat timer (32-bit down-counter):
  - If period_valid=0 when D_DONE occurs: load new_period-1 and set period_valid=1 on the same edge.
  - Otherwise the new period is held and loaded at the next reload; the count in progress is never truncated.
  - Each cycle the counter is nonzero it decrements. At 0: beat_pulse=1 for that cycle and reload with period-1, so the beat interval is exactly period cycles.
- On beat_pulse:
  - If auto_cycle=1, pending_face advances 0->1->2->0.
  - flash_req is set; repeated beats before a commit collapse into one request.
- When auto_cycle=0, pending_face = face_manual every cycle.
- Frame commit: triggers on a cycle with vid_valid & vid_ready & vid_eop, and updates outputs on the next clock edge (before pixel 0 of the next frame is handshaken).
  - face_select <= pending_face.
  - If flash_req: filter_select <= one-hot code for filter_mode, frames_left <= FLASH_FRAMES-1, and flash_req is cleared.
  - Else if frames_left>0: frames_left decrements and the filter is held.
  - Else: filter_select <= 0.
  - Net result: the filter is visible for exactly FLASH_FRAMES frames per flash request.
- Simultaneous beat and commit in the same cycle: the commit uses the pre-beat pending_face and flash_req; the beat's effect appears at the following commit.
- face_select and filter_select change only at commit edges, never mid-frame. filter_mode changes take effect at the next flash start only.

Test Plan:
1. Reset and divide (CLK_HZ=1000, so numerator 60000): bpm=120 strobed -> div_busy high 32 cycles; period_valid rises; beat_pulse every 500 cycles; outputs are 0 through reset.
2. Face cycling: auto_cycle=1, 3 beats, each followed by an eop handshake -> face_select goes 1, 2, 0. With auto_cycle=0 and face_manual=2 -> face_select=2 at the next commit.
3. Flash (FLASH_FRAMES=4, filter_mode=1): beat, then 5 commits -> filter_select=0010 for commits 1-4 and 0000 after commit 5.
4. Out-of-range and update: bpm=20 -> period_valid=0 and no beats. bpm=60 then bpm=240 during div_busy -> two divisions; periods 1000 then 250, with 250 loaded only at the next reload.
5. Corner cases: beat and eop handshake in the same cycle -> face changes one frame later. vid_ready=0 while eop is asserted -> no commit.
6. Async reset asserted mid-divide and mid-flash -> all outputs 0 immediately; no beat until a new bpm_valid.
